// File: rtl/insn_encoder.sv
// insn_encoder
// Packs decoded instruction fields back into 32-bit instruction words and
// streams them into instruction memory. Used by the boot/program loader and
// by benches that build imem images from symbolic instructions.
//
// Supported subset: R-type add/sub/and/or/sll/sra (opcode 00000, aluop 0..5)
// plus I-type addi (00101), sw (00111) and lw (01000).
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-low reset
//   start        one-cycle pulse: rewind pointer, clear count/full/err_illegal
//   in_valid     field bundle valid
//   in_ready     encoder can accept a bundle (high only in IDLE)
//   in_opcode    opcode field
//   in_rd        destination register
//   in_rs        source register 1
//   in_rt        source register 2 (R-type only)
//   in_shamt     shift amount (R-type only)
//   in_aluop     ALU function (R-type only)
//   in_imm       17-bit immediate (I-type only)
//   imem_we      write request, held until imem_ack
//   imem_addr    write address
//   imem_wdata   encoded word
//   imem_ack     imem accepted the write this cycle
//   count        words written since last start/reset
//   full         2**ADDR_W words written; input blocked until start
//   err_illegal  sticky flag for an unsupported opcode/aluop
module insn_encoder #(
    parameter int                 ADDR_W    = 12,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [16:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err_illegal
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    // Word count that means "memory completely written".
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    state_t            state_q,      state_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [31:0]       wdata_q,      wdata_d;
    logic [ADDR_W:0]   count_q,      count_d;
    logic              full_q,       full_d;
    logic              err_q,        err_d;
    logic              startPend_q,  startPend_d;

    logic              isLegal;
    logic [31:0]       encWord;
    logic [4:0]        rtField;
    logic [4:0]        shamtField;
    logic [ADDR_W:0]   countInc;

    // Combinational encoder. Fields that have no meaning for a given ALU
    // function are forced to zero so equivalent instructions always produce
    // the same word: shamt for add/sub/and/or, rt for the shifts.
    always_comb begin
        isLegal    = 1'b0;
        encWord    = '0;
        rtField    = '0;
        shamtField = '0;
        case (in_opcode)
            OP_RTYPE: begin
                if (in_aluop <= 5'd5) begin
                    isLegal    = 1'b1;
                    rtField    = (in_aluop >= 5'd4) ? 5'd0 : in_rt;
                    shamtField = (in_aluop >= 5'd4) ? in_shamt : 5'd0;
                    encWord    = {in_opcode, in_rd, in_rs, rtField,
                                  shamtField, in_aluop, 2'b00};
                end
            end
            OP_ADDI, OP_SW, OP_LW: begin
                isLegal = 1'b1;
                encWord = {in_opcode, in_rd, in_rs, in_imm};
            end
            default: ;
        endcase
    end

    assign countInc = count_q + (ADDR_W + 1)'(1);

    // Next-state logic. A start seen during WRITE is remembered and applied
    // on the ack edge in place of the normal advance, so the in-flight word
    // always lands at the address it was issued with.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        count_d     = count_q;
        full_d      = full_q;
        err_d       = err_q;
        startPend_d = startPend_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = BASE_ADDR;
                    count_d = '0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                end
                if (in_valid) begin
                    if (isLegal) begin
                        wdata_d = encWord;
                        state_d = WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (start) begin
                    startPend_d = 1'b1;
                end
                if (imem_ack) begin
                    startPend_d = 1'b0;
                    state_d     = IDLE;
                    if (startPend_q || start) begin
                        addr_d  = BASE_ADDR;
                        count_d = '0;
                        full_d  = 1'b0;
                        err_d   = 1'b0;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        count_d = countInc;
                        if (countInc == DEPTH) begin
                            full_d  = 1'b1;
                            state_d = FULL;
                        end
                    end
                end
            end
            FULL: begin
                if (start) begin
                    addr_d  = BASE_ADDR;
                    count_d = '0;
                    full_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset; reset drops any
    // pending write outright.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= BASE_ADDR;
            wdata_q     <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            startPend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            count_q     <= count_d;
            full_q      <= full_d;
            err_q       <= err_d;
            startPend_q <= startPend_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign imem_we     = (state_q == WRITE);
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign count       = count_q;
    assign full        = full_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_insn_encoder.sv
// tb_insn_encoder
// Directed bench for insn_encoder with ADDR_W=2 so the full/wrap path is
// reachable in a few writes. Inputs change and outputs are sampled 1 ns after
// each rising edge.
module tb_insn_encoder;

    localparam int ADDR_W = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_shamt;
    logic [4:0]        in_aluop;
    logic [16:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ack;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err_illegal;

    int nAsserts = 0;
    int nFails   = 0;

    insn_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR('0)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_shamt   (in_shamt),
        .in_aluop   (in_aluop),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ack   (imem_ack),
        .count      (count),
        .full       (full),
        .err_illegal(err_illegal)
    );

    always #5 clock = ~clock;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] sh,
                                 input logic [4:0] alu, input logic [16:0] imm);
        in_valid  = valid;
        in_opcode = op;
        in_rd     = rd;
        in_rs     = rs;
        in_rt     = rt;
        in_shamt  = sh;
        in_aluop  = alu;
        in_imm    = imm;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        imem_ack = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0);
        tick();
        tick();

        // Reset values
        checkOutput("rst_we",    32'(imem_we),     32'd0);
        checkOutput("rst_addr",  32'(imem_addr),   32'd0);
        checkOutput("rst_wdata", imem_wdata,       32'd0);
        checkOutput("rst_count", 32'(count),       32'd0);
        checkOutput("rst_full",  32'(full),        32'd0);
        checkOutput("rst_err",   32'(err_illegal), 32'd0);
        reset = 1'b1;
        tick();
        checkOutput("rst_ready", 32'(in_ready), 32'd1);

        // add $3,$1,$2 with shamt 7 -> shamt dropped, zero-wait ack
        imem_ack = 1'b1;
        applyStimulus(1'b1, 5'd0, 5'd3, 5'd1, 5'd2, 5'd7, 5'd0, 17'd0);
        tick();
        in_valid = 1'b0;
        checkOutput("add_we",    32'(imem_we),   32'd1);
        checkOutput("add_addr",  32'(imem_addr), 32'd0);
        checkOutput("add_wdata", imem_wdata,     32'h00C22000);
        checkOutput("add_ready", 32'(in_ready),  32'd0);
        tick();
        checkOutput("add_we_drop", 32'(imem_we),   32'd0);
        checkOutput("add_count",   32'(count),     32'd1);
        checkOutput("add_ready1",  32'(in_ready),  32'd1);
        checkOutput("add_addr1",   32'(imem_addr), 32'd1);
        tick();
        checkOutput("add_we_once", 32'(imem_we), 32'd0);

        // Rewind, then addi $1,$0,5 and sw $2,4($1) back-to-back
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("st_count", 32'(count),     32'd0);
        checkOutput("st_addr",  32'(imem_addr), 32'd0);
        applyStimulus(1'b1, 5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5);
        tick();
        checkOutput("addi_ready", 32'(in_ready),  32'd0);
        checkOutput("addi_addr",  32'(imem_addr), 32'd0);
        checkOutput("addi_wdata", imem_wdata,     32'h28400005);
        applyStimulus(1'b1, 5'b00111, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0, 17'd4);
        tick();
        checkOutput("sw_ready_pre", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("sw_ready", 32'(in_ready),  32'd0);
        checkOutput("sw_addr",  32'(imem_addr), 32'd1);
        checkOutput("sw_wdata", imem_wdata,     32'h38820004);
        tick();
        checkOutput("sw_count", 32'(count), 32'd2);

        // sll $4,$1,3 with rt=9 (dropped), ack withheld for 3 cycles
        imem_ack = 1'b0;
        applyStimulus(1'b1, 5'd0, 5'd4, 5'd1, 5'd9, 5'd3, 5'd4, 17'd0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("sll_we",    32'(imem_we),   32'd1);
            checkOutput("sll_addr",  32'(imem_addr), 32'd2);
            checkOutput("sll_wdata", imem_wdata,     32'h01020190);
            checkOutput("sll_count", 32'(count),     32'd2);
            if (i == 3) imem_ack = 1'b1;
            tick();
        end
        checkOutput("sll_count_ack", 32'(count),   32'd3);
        checkOutput("sll_we_drop",   32'(imem_we), 32'd0);

        // Illegal opcode, then R-type with aluop 6
        applyStimulus(1'b1, 5'b00010, 5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 17'd1);
        tick();
        checkOutput("ill1_ready", 32'(in_ready),    32'd1);
        checkOutput("ill1_we",    32'(imem_we),     32'd0);
        checkOutput("ill1_err",   32'(err_illegal), 32'd1);
        applyStimulus(1'b1, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 5'd6, 17'd0);
        tick();
        in_valid = 1'b0;
        checkOutput("ill2_we",    32'(imem_we),     32'd0);
        checkOutput("ill2_count", 32'(count),       32'd3);
        checkOutput("ill2_err",   32'(err_illegal), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("ill_clr_err", 32'(err_illegal), 32'd0);

        // Fill all four words
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'(k));
            tick();
            in_valid = 1'b0;
            checkOutput("fill_addr",  32'(imem_addr), 32'(k));
            checkOutput("fill_wdata", imem_wdata,     32'h28400000 | 32'(k));
            tick();
        end
        checkOutput("full_flag",  32'(full),      32'd1);
        checkOutput("full_ready", 32'(in_ready),  32'd0);
        checkOutput("full_addr",  32'(imem_addr), 32'd0);
        checkOutput("full_count", 32'(count),     32'd4);

        // Held-off bundle with unknown fields must change nothing
        in_valid  = 1'b1;
        in_opcode = 'x;
        in_rd     = 'x;
        in_rs     = 'x;
        in_rt     = 'x;
        in_shamt  = 'x;
        in_aluop  = 'x;
        in_imm    = 'x;
        tick();
        tick();
        checkOutput("hold_we",    32'(imem_we),     32'd0);
        checkOutput("hold_count", 32'(count),       32'd4);
        checkOutput("hold_wdata", imem_wdata,       32'h28400003);
        checkOutput("hold_err",   32'(err_illegal), 32'd0);

        // start from FULL, then the waiting bundle goes to address 0
        applyStimulus(1'b1, 5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd9);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("rew_ready", 32'(in_ready), 32'd1);
        checkOutput("rew_full",  32'(full),     32'd0);
        checkOutput("rew_count", 32'(count),    32'd0);
        tick();
        in_valid = 1'b0;
        checkOutput("rew_we",    32'(imem_we),   32'd1);
        checkOutput("rew_addr",  32'(imem_addr), 32'd0);
        checkOutput("rew_wdata", imem_wdata,     32'h28400009);
        tick();
        checkOutput("rew_count1", 32'(count), 32'd1);

        // start during a stalled WRITE: write finishes at address 1, then rewind
        imem_ack = 1'b0;
        applyStimulus(1'b1, 5'd0, 5'd3, 5'd1, 5'd2, 5'd7, 5'd0, 17'd0);
        tick();
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("mw_we",    32'(imem_we),   32'd1);
        checkOutput("mw_addr",  32'(imem_addr), 32'd1);
        checkOutput("mw_wdata", imem_wdata,     32'h00C22000);
        checkOutput("mw_count", 32'(count),     32'd1);
        imem_ack = 1'b1;
        tick();
        checkOutput("mw_addr0",  32'(imem_addr), 32'd0);
        checkOutput("mw_count0", 32'(count),     32'd0);
        checkOutput("mw_we0",    32'(imem_we),   32'd0);

        // start coincident with an accept: bundle lands at BASE_ADDR
        applyStimulus(1'b1, 5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd1);
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("co_pre_addr", 32'(imem_addr), 32'd1);
        applyStimulus(1'b1, 5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd2);
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput("co_we",    32'(imem_we),   32'd1);
        checkOutput("co_addr",  32'(imem_addr), 32'd0);
        checkOutput("co_wdata", imem_wdata,     32'h28400002);
        checkOutput("co_count", 32'(count),     32'd0);
        tick();
        checkOutput("co_count1", 32'(count), 32'd1);

        // reset during a stalled WRITE drops the word
        imem_ack = 1'b0;
        applyStimulus(1'b1, 5'd0, 5'd4, 5'd1, 5'd9, 5'd3, 5'd4, 17'd0);
        tick();
        in_valid = 1'b0;
        checkOutput("rw_we_pre", 32'(imem_we), 32'd1);
        reset = 1'b0;
        tick();
        checkOutput("rw_we",    32'(imem_we),   32'd0);
        checkOutput("rw_addr",  32'(imem_addr), 32'd0);
        checkOutput("rw_wdata", imem_wdata,     32'd0);
        checkOutput("rw_count", 32'(count),     32'd0);
        checkOutput("rw_full",  32'(full),      32'd0);
        reset    = 1'b1;
        imem_ack = 1'b1;
        tick();
        checkOutput("rw_ready", 32'(in_ready), 32'd1);
        checkOutput("rw_we2",   32'(imem_we),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/insn_encoder.md
Name: insn_encoder

Overview:
- Inverse of the processor control decoder: accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit instruction words.
- Writes each word into instruction memory through a write port with an acknowledge handshake, advancing an address pointer after each write.
- Used by the boot/program loader and by test benches to build imem images from symbolic instructions.
- Supports the current ISA subset: R-type add/sub/and/or/sll/sra, plus addi, sw and lw.

Parameters:
ADDR_W, 12, imem address width; capacity DEPTH = 2**ADDR_W words
BASE_ADDR, 0, address loaded into the write pointer on reset and on start

Ports:
clock  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle pulse; rewinds the pointer to BASE_ADDR and clears count, full and err_illegal
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle
in_opcode  input  5  instruction opcode
in_rd  input  5  destination register
in_rs  input  5  source register 1
in_rt  input  5  source register 2 (R-type)
in_shamt  input  5  shift amount (R-type)
in_aluop  input  5  ALU function (R-type)
in_imm  input  17  immediate (I-type)
imem_we  output  1  imem write request; held until acknowledged
imem_addr  output  ADDR_W  write address
imem_wdata  output  32  encoded word
imem_ack  input  1  imem accepted the write this cycle
count  output  ADDR_W+1  words written since the last start or reset
full  output  1  DEPTH words written
err_illegal  output  1  sticky: an unsupported opcode/aluop was received

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, full=0, err_illegal=0.
  - in_ready is 1 from the first cycle after reset releases.
  - Reset overrides everything, including a write in progress; the pending word is dropped.
- States: IDLE, WRITE, FULL.
- in_ready = (state==IDLE). A transfer occurs when in_valid && in_ready at a clock edge.
- Encoding (registered on the accept edge):
  - R-type (opcode 00000): [31:27]=opcode, [26:22]=rd, [21:17]=rs, [16:12]=rt, [11:7]=shamt, [6:2]=aluop, [1:0]=00.
    - For aluop 00000–00011, shamt is forced to 0.
    - For aluop 00100/00101 (sll/sra), rt is forced to 0.
  - I-type (opcode 00101 addi, 00111 sw, 01000 lw): [31:27]=opcode, [26:22]=rd, [21:17]=rs, [16:0]=imm. The rt, shamt and aluop inputs are ignored.
- Illegal input: any other opcode, or R-type with aluop > 00101.
  - The bundle is still accepted (handshake completes).
  - Nothing is written; count and state are unchanged.
  - err_illegal is set on that edge and stays set until start or reset.
- IDLE, legal accept: imem_wdata is loaded, imem_we=1 from the next cycle, state goes to WRITE. Write latency from accept to first imem_we cycle is 1 cycle.
- WRITE:
  - imem_we, imem_addr and imem_wdata are held stable until imem_ack==1.
  - On the ack edge: imem_we=0, count+1, and the pointer advances.
  - If the new count==DEPTH: full=1 and state goes to FULL. Otherwise state returns to IDLE.
  - Peak throughput is one word per 2 cycles (zero-wait imem).
- imem_ack outside WRITE is ignored.
- Pointer: increments by 1 modulo DEPTH, so it wraps from 2**ADDR_W−1 to 0. The wrap happens only on the ack that fills the memory (with BASE_ADDR=0) and the pointer never overwrites, because FULL blocks further input.
- FULL: in_ready=0 and imem_we=0 until start.
- start:
  - In IDLE or FULL: on that edge, pointer=BASE_ADDR, count=0, full=0, err_illegal=0, state=IDLE.
  - In WRITE: the pulse is latched, the current write completes normally, and the rewind is applied on the ack edge instead of the advance. The latched start overrides the FULL transition.
  - start coincident with an accept in IDLE: the rewind takes effect and the bundle is accepted and written at BASE_ADDR.
- in_valid with X fields while in_ready==0 must have no effect.

Test Plan:
- Reset then add $3,$1,$2 (op 0, rd3 rs1 rt2 shamt 7 aluop 0), imem_ack tied 1 -> imem_we for exactly 1 cycle, addr 0, wdata 0x00C22000 (shamt zeroed), count=1, in_ready back to 1 the next cycle.
- addi $1,$0,5 then sw $2,4($1) back-to-back, zero-wait ack -> wdata 0x28400005 @0, then 0x38820004 @1; in_ready toggles 1,0,1,0.
- sll $4,$1,3 with in_rt=9, ack delayed 3 cycles -> imem_we, addr and wdata (0x01020190) stable for 4 cycles; count increments only on the ack cycle.
- opcode 00010, then add aluop 00110 -> both accepted, no imem_we, count unchanged, err_illegal=1; next start clears it.
- ADDR_W=2, 4 writes -> full=1, in_ready=0, pointer wrapped to 0, count=4; a 5th bundle is held off; start -> in_ready=1 and the next write goes to addr 0.
- start pulsed mid-WRITE (ack delayed), and separately reset pulsed mid-WRITE -> start case: the write completes at the old address, then the pointer is 0 and count=0. Reset case: imem_we drops the next cycle and all outputs take their reset values.
